// File: rtl/gray_counter.sv
// Up/down binary counter with registered binary and Gray views, loadable in either code; optional GRAY_COUNTER_CHECK_EN self-check drives err.
// Latency: every request sampled on edge N is visible after edge N; no combinational input-to-output path.
// Backpressure: none; accepts one load or step per cycle, priority !rst_n > load > en > hold.
module gray_counter #(
  parameter int WIDTH = 5,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             err
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             tc_q;

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic [WIDTH-1:0] load_bin;
  logic             tc_nxt;
  logic             blocked;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state selection: load beats step, steps at an end wrap or are blocked.
  always_comb begin
    bin_nxt  = bin_q;
    tc_nxt   = 1'b0;
    blocked  = 1'b0;
    load_bin = load_gray ? gray2bin(load_val) : load_val;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_q == {WIDTH{1'b1}}) begin
          tc_nxt = 1'b1;
          if (WRAP != 0) bin_nxt = '0;
          else           blocked = 1'b1;
        end else begin
          bin_nxt = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          tc_nxt = 1'b1;
          if (WRAP != 0) bin_nxt = {WIDTH{1'b1}};
          else           blocked = 1'b1;
        end else begin
          bin_nxt = bin_q - WIDTH'(1);
        end
      end
    end
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);
  end

  // Binary, Gray and terminal-count registers all update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      tc_q   <= tc_nxt;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;

`ifdef GRAY_COUNTER_CHECK_EN
  logic             err_q;
  logic             stepped;
  logic [WIDTH-1:0] gray_diff;

  // Only real count steps are checked; loads, holds and blocked steps may move any number of bits.
  assign stepped   = !load && en && !blocked;
  assign gray_diff = gray_q ^ gray_nxt;

  // Sticky flag: set when a step changes other than exactly one Gray bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (stepped && ($countones(gray_diff) != 1)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at WIDTH=5, driving a wrapping and a saturating instance in parallel.
// Latency: each driven vector's expectation is checked #1 after the following rising edge.
// Backpressure: none; the monitor pops one expectation per edge while any are queued.
module tb_gray_counter;

  typedef struct {
    int         idx;
    logic [4:0] wb;
    logic [4:0] wg;
    logic       wt;
    logic [4:0] sb;
    logic [4:0] sg;
    logic       st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic       load_gray = 1'b0;
  logic [4:0] load_val = '0;

  logic [4:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_tc, s_tc, w_err, s_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   vec_n = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(5), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_gray(load_gray), .load_val(load_val),
    .bin_out(w_bin), .gray_out(w_gray), .tc(w_tc), .err(w_err)
  );

  gray_counter #(.WIDTH(5), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_gray(load_gray), .load_val(load_val),
    .bin_out(s_bin), .gray_out(s_gray), .tc(s_tc), .err(s_err)
  );

  task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, req);
    end
  endtask

  // Monitor: every edge with a queued expectation is compared against both instances.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wrap_bin",  e.idx, w_bin,  e.wb);
      chk("wrap_gray", e.idx, w_gray, e.wg);
      chk("wrap_tc",   e.idx, {4'd0, w_tc},  {4'd0, e.wt});
      chk("wrap_err",  e.idx, {4'd0, w_err}, 5'd0);
      chk("sat_bin",   e.idx, s_bin,  e.sb);
      chk("sat_gray",  e.idx, s_gray, e.sg);
      chk("sat_tc",    e.idx, {4'd0, s_tc},  {4'd0, e.st});
      chk("sat_err",   e.idx, {4'd0, s_err}, 5'd0);
    end
  end

  // Drive one vector at the falling edge and queue what both instances must show after the next rising edge.
  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic lg,
                       input logic [4:0] lv,
                       input logic [4:0] wb, input logic [4:0] wg, input logic wt,
                       input logic [4:0] sb, input logic [4:0] sg, input logic st);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; up = u; load = l; load_gray = lg; load_val = lv;
    x.idx = vec_n; x.wb = wb; x.wg = wg; x.wt = wt; x.sb = sb; x.sg = sg; x.st = st;
    exp_q.push_back(x);
    vec_n++;
  endtask

  initial begin
    int wbm, sbm;
    logic       wtm, stm;
    logic [4:0] wv, sv;
    //     rst en up ld lg  val    wbin wgray wtc  sbin sgray stc
    drive(0, 0, 0, 0, 0, 5'd0,   5'd0,  5'd0,  0,  5'd0,  5'd0,  0); // reset
    drive(0, 1, 1, 0, 0, 5'd0,   5'd0,  5'd0,  0,  5'd0,  5'd0,  0); // reset beats en
    drive(1, 1, 1, 0, 0, 5'd0,   5'd1,  5'd1,  0,  5'd1,  5'd1,  0);
    drive(1, 1, 1, 0, 0, 5'd0,   5'd2,  5'd3,  0,  5'd2,  5'd3,  0);
    drive(1, 1, 1, 0, 0, 5'd0,   5'd3,  5'd2,  0,  5'd3,  5'd2,  0);
    drive(1, 0, 0, 1, 0, 5'd7,   5'd7,  5'd4,  0,  5'd7,  5'd4,  0); // binary load 7
    drive(1, 1, 1, 0, 0, 5'd0,   5'd8,  5'd12, 0,  5'd8,  5'd12, 0);
    drive(1, 1, 1, 1, 1, 5'd4,   5'd7,  5'd4,  0,  5'd7,  5'd4,  0); // gray load wins over en
    drive(1, 0, 1, 0, 0, 5'd0,   5'd7,  5'd4,  0,  5'd7,  5'd4,  0); // hold
    drive(1, 0, 0, 1, 0, 5'd31,  5'd31, 5'd16, 0,  5'd31, 5'd16, 0);
    drive(1, 1, 1, 0, 0, 5'd0,   5'd0,  5'd0,  1,  5'd31, 5'd16, 1); // wrap vs block at top
    drive(1, 1, 0, 0, 0, 5'd0,   5'd31, 5'd16, 1,  5'd30, 5'd17, 0); // wrap down past 0
    drive(1, 0, 0, 1, 0, 5'd31,  5'd31, 5'd16, 0,  5'd31, 5'd16, 0);
    drive(1, 1, 1, 0, 0, 5'd0,   5'd0,  5'd0,  1,  5'd31, 5'd16, 1);
    drive(1, 1, 1, 0, 0, 5'd0,   5'd1,  5'd1,  0,  5'd31, 5'd16, 1);
    drive(1, 1, 1, 0, 0, 5'd0,   5'd2,  5'd3,  0,  5'd31, 5'd16, 1);
    drive(1, 0, 0, 1, 0, 5'd0,   5'd0,  5'd0,  0,  5'd0,  5'd0,  0); // load clears tc
    drive(1, 1, 0, 0, 0, 5'd0,   5'd31, 5'd16, 1,  5'd0,  5'd0,  1);
    drive(1, 1, 0, 0, 0, 5'd0,   5'd30, 5'd17, 0,  5'd0,  5'd0,  1);
    drive(1, 0, 0, 0, 0, 5'd0,   5'd30, 5'd17, 0,  5'd0,  5'd0,  0); // hold clears tc
    drive(1, 0, 0, 1, 0, 5'd12,  5'd12, 5'd10, 0,  5'd12, 5'd10, 0);
    drive(0, 1, 1, 1, 0, 5'd5,   5'd0,  5'd0,  0,  5'd0,  5'd0,  0); // reset beats load
    drive(1, 0, 0, 1, 1, 5'd31,  5'd21, 5'd31, 0,  5'd21, 5'd31, 0); // gray 11111 -> bin 10101
    drive(1, 1, 1, 0, 0, 5'd0,   5'd22, 5'd29, 0,  5'd22, 5'd29, 0);
    drive(1, 0, 0, 1, 0, 5'd0,   5'd0,  5'd0,  0,  5'd0,  5'd0,  0);

    // 64-step up then 64-step down sweep; err must stay low throughout.
    wbm = 0; sbm = 0;
    for (int dir = 1; dir >= 0; dir--) begin
      for (int k = 0; k < 64; k++) begin
        if (dir == 1) begin
          wtm = (wbm == 31); wbm = (wbm + 1) % 32;
          stm = (sbm == 31); if (!stm) sbm = sbm + 1;
        end else begin
          wtm = (wbm == 0); wbm = (wbm + 31) % 32;
          stm = (sbm == 0); if (!stm) sbm = sbm - 1;
        end
        wv = wbm[4:0];
        sv = sbm[4:0];
        drive(1, 1, dir[0], 0, 0, 5'd0, wv, wv ^ (wv >> 1), wtm, sv, sv ^ (sv >> 1), stm);
      end
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
